// File: rtl/aes_dec_stream_ctrl_if.sv
// Stream-side bundle of the AES decryption stream controller: key offer,
// ciphertext input and plaintext output handshakes.
interface aes_dec_stream_ctrl_if;
  localparam int unsigned KEY_W = 256;
  localparam int unsigned BLK_W = 128;

  logic             key_v_i;
  logic [KEY_W-1:0] key_i;
  logic             key_ready_o;
  logic             v_i;
  logic [BLK_W-1:0] ciphertext_i;
  logic             ready_o;
  logic             v_o;
  logic [BLK_W-1:0] plaintext_o;
  logic             ready_i;

  // Controller side
  modport slave (
    input  key_v_i, key_i, v_i, ciphertext_i, ready_i,
    output key_ready_o, ready_o, v_o, plaintext_o
  );

  // Producer/consumer side
  modport master (
    output key_v_i, key_i, v_i, ciphertext_i, ready_i,
    input  key_ready_o, ready_o, v_o, plaintext_o
  );
endinterface

// File: rtl/aes_dec_stream_ctrl.sv
// Stream controller for a non-stallable pipelined AES-256 decryption core:
// credit-based admission, valid delay line tracking in-flight blocks, output
// FIFO capture, and drain-then-warm sequencing of key changes.
module aes_dec_stream_ctrl #(
  parameter int unsigned LATENCY_P    = 14,
  parameter int unsigned KEY_LAT_P    = 2,
  parameter int unsigned FIFO_DEPTH_P = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  aes_dec_stream_ctrl_if.slave   s_if,
  output logic [255:0]           core_key_o,
  output logic [127:0]           core_ciphertext_o,
  input  logic [127:0]           core_plaintext_i
);

  localparam int unsigned KEY_W = 256;
  localparam int unsigned BLK_W = 128;
  localparam int unsigned AW    = (FIFO_DEPTH_P > 1) ? $clog2(FIFO_DEPTH_P) : 1;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned IW    = $clog2(LATENCY_P + 1);
  localparam int unsigned SW    = $clog2(FIFO_DEPTH_P + LATENCY_P + 1);
  localparam int unsigned WW    = $clog2(KEY_LAT_P + 1);

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    WARM  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WW-1:0]      warm_q, warm_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [BLK_W-1:0]   ct_q, ct_d;
  logic [LATENCY_P-1:0] dl_q, dl_d;
  logic [IW-1:0]      infl_q, infl_d;
  logic [AW-1:0]      wr_q, wr_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               v_q, v_d;
  logic [BLK_W-1:0]   mem_q [FIFO_DEPTH_P];

  logic key_ready_c;
  logic key_acc_c;
  logic credit_ok_c;
  logic ready_c;
  logic acc_c;
  logic push_c;
  logic pop_c;

  // Handshake qualifiers; admission uses registered counts only
  always_comb begin
    key_ready_c = (state_q == NOKEY) || (state_q == RUN);
    key_acc_c   = s_if.key_v_i && key_ready_c;
    credit_ok_c = (SW'(cnt_q) + SW'(infl_q)) < SW'(FIFO_DEPTH_P);
    ready_c     = (state_q == RUN) && !s_if.key_v_i && credit_ok_c;
    acc_c       = s_if.v_i && ready_c;
    push_c      = dl_q[LATENCY_P-1];
    pop_c       = v_q && s_if.ready_i;
  end

  // Key sequencing FSM: next state, warm-up counter, core key and shadow key
  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    key_d    = key_q;
    shadow_d = shadow_q;
    case (state_q)
      NOKEY: begin
        if (key_acc_c) begin
          key_d   = s_if.key_i;
          warm_d  = WW'(KEY_LAT_P);
          state_d = WARM;
        end
      end
      WARM: begin
        warm_d = warm_q - WW'(1);
        if (warm_q <= WW'(1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (key_acc_c) begin
          shadow_d = s_if.key_i;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (infl_q == '0) begin
          key_d   = shadow_q;
          warm_d  = WW'(KEY_LAT_P);
          state_d = WARM;
        end
      end
      default: state_d = NOKEY;
    endcase
  end

  // Datapath next state: issue register, valid delay line, FIFO pointers/count
  always_comb begin
    ct_d  = acc_c ? s_if.ciphertext_i : ct_q;
    dl_d  = '0;
    dl_d[0] = acc_c;
    for (int i = 1; i < int'(LATENCY_P); i++) begin
      dl_d[i] = dl_q[i-1];
    end
    infl_d = infl_q + IW'(acc_c) - IW'(push_c);
    wr_d   = push_c ? wr_q + AW'(1) : wr_q;
    rd_d   = pop_c ? rd_q + AW'(1) : rd_q;
    cnt_d  = cnt_q + CW'(push_c) - CW'(pop_c);
    v_d    = (cnt_d != '0);
  end

  // Control and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= NOKEY;
      warm_q   <= '0;
      key_q    <= '0;
      shadow_q <= '0;
      ct_q     <= '0;
      dl_q     <= '0;
      infl_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      key_q    <= key_d;
      shadow_q <= shadow_d;
      ct_q     <= ct_d;
      dl_q     <= dl_d;
      infl_q   <= infl_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      v_q      <= v_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      mem_q[wr_q] <= core_plaintext_i;
    end
  end

  // Credit admission must make a push into a full FIFO impossible
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(push_c && !pop_c && (cnt_q == CW'(FIFO_DEPTH_P))));
    end
  end

  assign s_if.key_ready_o = key_ready_c;
  assign s_if.ready_o     = ready_c;
  assign s_if.v_o         = v_q;
  assign s_if.plaintext_o = mem_q[rd_q];
  assign core_key_o        = key_q;
  assign core_ciphertext_o = ct_q;

endmodule

// File: tb/tb_aes_dec_stream_ctrl.sv
// Bench for aes_dec_stream_ctrl: stand-in pipelined core plus a
// transaction-level reference model (queue of expected plaintexts with
// arrival times, credit and key-sequencing rules in edge arithmetic).
module tb_aes_dec_stream_ctrl;

  localparam int unsigned LAT   = 14;
  localparam int unsigned KL    = 2;
  localparam int unsigned DEPTH = 16;

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic [255:0] core_key;
  logic [127:0] core_ct;
  logic [127:0] core_pt;

  aes_dec_stream_ctrl_if bus ();

  aes_dec_stream_ctrl #(
    .LATENCY_P   (LAT),
    .KEY_LAT_P   (KL),
    .FIFO_DEPTH_P(DEPTH)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .s_if             (bus),
    .core_key_o       (core_key),
    .core_ciphertext_o(core_ct),
    .core_plaintext_i (core_pt)
  );

  always #5 clk_i = ~clk_i;

  int unsigned edge_n = 0;
  always @(posedge clk_i) edge_n++;

  // Stand-in decryption core: known-answer for the FIPS vector, keyed mix otherwise
  function automatic logic [127:0] core_fn(input logic [127:0] c, input logic [255:0] k);
    if (k == FIPS_KEY && c == FIPS_CT) return FIPS_PT;
    return c ^ k[255:128] ^ {k[63:0], k[127:64]};
  endfunction

  // Non-stallable core pipeline, result valid LAT edges after the issue register
  logic [127:0] pipe [LAT-1];
  always @(posedge clk_i) begin
    pipe[0] <= core_fn(core_ct, core_key);
    for (int i = 1; i < int'(LAT) - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign core_pt = pipe[LAT-2];

  // Reference model state
  typedef struct {
    logic [127:0] pt;
    int unsigned  arr;
  } exp_t;

  exp_t         exp_q[$];
  bit           have_key = 1'b0;
  logic [255:0] cur_key  = '0;
  int unsigned  run_edge = 0;
  int unsigned  last_arr = 0;
  int unsigned  n_acc    = 0;
  int unsigned  n_pop    = 0;
  int unsigned  n_vec    = 0;
  int unsigned  n_err    = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: drive at negedge, check against model, advance model at posedge
  task automatic step(input bit kv, input logic [255:0] k, input bit dv,
                      input logic [127:0] c, input bit rdy);
    int unsigned e_nxt;
    bit exp_v, exp_kr, exp_rdy;
    exp_t ent;
    bus.key_v_i      = kv;
    bus.key_i        = k;
    bus.v_i          = dv;
    bus.ciphertext_i = c;
    bus.ready_i      = rdy;
    #1;
    e_nxt   = edge_n + 1;
    exp_v   = (exp_q.size() != 0) && (exp_q[0].arr <= edge_n);
    exp_kr  = !have_key || (e_nxt >= run_edge);
    exp_rdy = have_key && (e_nxt >= run_edge) && !kv && (exp_q.size() < DEPTH);
    check_eq("v_o", 256'(bus.v_o), 256'(exp_v));
    if (exp_v) check_eq("plaintext_o", 256'(bus.plaintext_o), 256'(exp_q[0].pt));
    check_eq("key_ready_o", 256'(bus.key_ready_o), 256'(exp_kr));
    check_eq("ready_o", 256'(bus.ready_o), 256'(exp_rdy));
    @(posedge clk_i);
    if (kv && exp_kr) begin
      if (!have_key) begin
        have_key = 1'b1;
        run_edge = e_nxt + KL + 1;
      end else begin
        run_edge = ((e_nxt > last_arr) ? e_nxt : last_arr) + KL + 2;
      end
      cur_key = k;
    end
    if (dv && exp_rdy) begin
      ent.pt  = core_fn(c, cur_key);
      ent.arr = e_nxt + LAT;
      exp_q.push_back(ent);
      last_arr = ent.arr;
      n_acc++;
    end
    if (exp_v && rdy) begin
      void'(exp_q.pop_front());
      n_pop++;
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, rdy);
  endtask

  task automatic wait_run(input bit rdy);
    for (int i = 0; i < 80 && !(have_key && (edge_n + 1 >= run_edge)); i++)
      step(1'b0, '0, 1'b0, '0, rdy);
  endtask

  task automatic do_reset();
    bus.key_v_i = 1'b0; bus.key_i = '0; bus.v_i = 1'b0;
    bus.ciphertext_i = '0; bus.ready_i = 1'b0;
    reset_n_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    exp_q.delete();
    have_key = 1'b0;
    cur_key  = '0;
    run_edge = 0;
    last_arr = 0;
  endtask

  // n+1 blocks so the last arrives with n already queued; pop on that same edge
  task automatic push_pop_at(input int n);
    int unsigned pop0;
    pop0 = n_pop;
    for (int i = 0; i <= n; i++) step(1'b0, '0, 1'b1, rand_blk(), 1'b0);
    for (int i = 0; i < 40 && (edge_n + 1 < last_arr); i++) idle(1, 1'b0);
    idle(1, 1'b1);
    check_eq("pp_v_after", 256'(bus.v_o), 256'(1));
    idle(40, 1'b1);
    check_eq("pp_pops", 256'(n_pop - pop0), 256'(n + 1));
  endtask

  initial begin
    int unsigned acc0;
    logic [255:0] k2;

    @(negedge clk_i);
    do_reset();
    check_eq("rst_key_ready", 256'(bus.key_ready_o), 256'(1));
    check_eq("rst_core_key", core_key, 256'(0));
    check_eq("rst_core_ct", 256'(core_ct), 256'(0));
    idle(3, 1'b1);

    // FIPS-197 C.3 known answer and exact latency
    step(1'b1, FIPS_KEY, 1'b0, '0, 1'b0);
    check_eq("fips_core_key", core_key, FIPS_KEY);
    wait_run(1'b0);
    step(1'b0, '0, 1'b1, FIPS_CT, 1'b0);
    check_eq("fips_core_ct", 256'(core_ct), 256'(FIPS_CT));
    idle(13, 1'b0);
    check_eq("fips_v_at_13", 256'(bus.v_o), 256'(0));
    idle(1, 1'b0);
    check_eq("fips_v_at_14", 256'(bus.v_o), 256'(1));
    check_eq("fips_pt", 256'(bus.plaintext_o), 256'(FIPS_PT));
    idle(2, 1'b1);

    // 100 back-to-back blocks with a free-running consumer
    acc0 = n_acc;
    for (int i = 0; i < 200 && (n_acc - acc0) < 100; i++) begin
      if ((n_acc - acc0) < 100) step(1'b0, '0, 1'b1, rand_blk(), 1'b1);
    end
    check_eq("stream_cnt", 256'(n_acc - acc0), 256'(100));
    idle(20, 1'b1);

    // Stalled consumer: credit admits exactly DEPTH blocks
    acc0 = n_acc;
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, rand_blk(), 1'b0);
    check_eq("bp_accepted", 256'(n_acc - acc0), 256'(DEPTH));
    check_eq("bp_ready", 256'(bus.ready_o), 256'(0));
    check_eq("bp_v", 256'(bus.v_o), 256'(1));
    idle(30, 1'b1);

    // Key change with 5 blocks in flight
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, rand_blk(), 1'b1);
    k2 = rand_key();
    step(1'b1, k2, 1'b0, '0, 1'b1);
    idle(4, 1'b1);
    check_eq("drain_key_hold", core_key, FIPS_KEY);
    wait_run(1'b1);
    check_eq("new_core_key", core_key, k2);
    step(1'b0, '0, 1'b1, rand_blk(), 1'b1);
    idle(20, 1'b1);

    // Simultaneous push and pop at both FIFO occupancy extremes
    push_pop_at(int'(DEPTH) - 1);
    push_pop_at(1);

    // Randomized mix of key changes, offers and consumer stalls
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), rand_key(), 1'($urandom), rand_blk(),
           ($urandom_range(0, 3) != 0));
    end
    idle(40, 1'b1);

    // Reset with 8 results queued drops everything
    wait_run(1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, rand_blk(), 1'b0);
    idle(20, 1'b0);
    check_eq("pre_rst_v", 256'(bus.v_o), 256'(1));
    do_reset();
    check_eq("mid_rst_v", 256'(bus.v_o), 256'(0));
    check_eq("mid_rst_ready", 256'(bus.ready_o), 256'(0));
    check_eq("mid_rst_key_ready", 256'(bus.key_ready_o), 256'(1));
    check_eq("mid_rst_core_key", core_key, 256'(0));
    idle(20, 1'b1);

    // Post-reset recovery
    step(1'b1, rand_key(), 1'b0, '0, 1'b1);
    wait_run(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, rand_blk(), 1'b1);
    idle(20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
